// File: rtl/sync_delay_ctrl.sv
// Programmable sync-pulse delay stage ahead of the biplex FFT counter.
// Emits a one-cycle sync_out a programmed number of enabled cycles after sync_in.
module sync_delay_ctrl #(
  parameter int DELAY_W = 16,
  parameter bit RETRIG  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               sync_in,
  input  logic [DELAY_W-1:0] delay,
  output logic               sync_out,
  output logic               busy,
  output logic [DELAY_W-1:0] count_left,
  output logic               overrun
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t             state, state_n;
  logic [DELAY_W-1:0] cnt_n;
  logic               pulse_n;
  logic               ovr_n;
  logic               pend, pend_n;
  logic               expire;
  logic               dly_zero;

  assign expire   = (count_left == DELAY_W'(1));
  assign dly_zero = (delay == '0);
  assign busy     = (state == COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count_left <= '0;
      sync_out   <= 1'b0;
      overrun    <= 1'b0;
      pend       <= 1'b0;
    end else begin
      state      <= state_n;
      count_left <= cnt_n;
      sync_out   <= pulse_n;
      overrun    <= ovr_n;
      pend       <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = count_left;
    pulse_n = 1'b0;
    ovr_n   = overrun;
    pend_n  = pend;
    if (ena) begin
      unique case (state)
        IDLE: begin
          // pend holds the second pulse of a zero-delay reload at expiry
          if (pend) begin
            pulse_n = 1'b1;
            pend_n  = 1'b0;
          end
          if (sync_in) begin
            if (dly_zero) begin
              pulse_n = 1'b1;
            end else begin
              cnt_n   = delay;
              state_n = COUNT;
            end
          end
        end
        COUNT: begin
          if (sync_in && RETRIG) begin
            if (expire) pulse_n = 1'b1;
            if (dly_zero) begin
              cnt_n   = '0;
              state_n = IDLE;
              if (expire) pend_n  = 1'b1;
              else        pulse_n = 1'b1;
            end else begin
              cnt_n = delay;
            end
          end else begin
            if (sync_in) ovr_n = 1'b1;
            if (expire) begin
              pulse_n = 1'b1;
              cnt_n   = '0;
              state_n = IDLE;
            end else begin
              cnt_n = count_left - DELAY_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_delay_ctrl.sv
// Directed bench for sync_delay_ctrl.
// Runs a RETRIG=0 and a RETRIG=1 instance side by side on shared stimulus.
module tb_sync_delay_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, ena, sync_in;
  logic [W-1:0] delay;

  logic         so_a, busy_a, ovr_a;
  logic [W-1:0] cnt_a;
  logic         so_b, busy_b, ovr_b;
  logic [W-1:0] cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_delay_ctrl #(.DELAY_W(W), .RETRIG(1'b0)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .sync_in(sync_in), .delay(delay),
    .sync_out(so_a), .busy(busy_a), .count_left(cnt_a), .overrun(ovr_a)
  );

  sync_delay_ctrl #(.DELAY_W(W), .RETRIG(1'b1)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .sync_in(sync_in), .delay(delay),
    .sync_out(so_b), .busy(busy_b), .count_left(cnt_b), .overrun(ovr_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sync_in = 1'b0; ena = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    delay = 16'd3;
    do_reset();
    n_chk++;
    if ({so_a, busy_a, cnt_a, ovr_a} !== {1'b0, 1'b0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_a: so=%b busy=%b cnt=%0d ovr=%b want all 0",
               so_a, busy_a, cnt_a, ovr_a);
    end
    n_chk++;
    if ({so_b, busy_b, cnt_b, ovr_b} !== {1'b0, 1'b0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_b: so=%b busy=%b cnt=%0d ovr=%b want all 0",
               so_b, busy_b, cnt_b, ovr_b);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_cnt [7] = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0};
    logic         exp_so  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         exp_bsy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    delay = 16'd5; sync_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      sync_in = 1'b0;
      delay = 16'd9;
      n_chk++;
      if ({so_a, busy_a, cnt_a} !== {exp_so[i], exp_bsy[i], exp_cnt[i]}) begin
        n_fail++;
        $display("FAIL basic_a[%0d]: so=%b busy=%b cnt=%0d want %b %b %0d",
                 i, so_a, busy_a, cnt_a, exp_so[i], exp_bsy[i], exp_cnt[i]);
      end
      n_chk++;
      if ({so_b, busy_b, cnt_b} !== {exp_so[i], exp_bsy[i], exp_cnt[i]}) begin
        n_fail++;
        $display("FAIL basic_b[%0d]: so=%b busy=%b cnt=%0d want %b %b %0d",
                 i, so_b, busy_b, cnt_b, exp_so[i], exp_bsy[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    delay = 16'd0; sync_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sync_in = 1'b0;
      step();
      n_chk++;
      if ({so_a, busy_a, cnt_a} !== {1'b1, 1'b0, 16'd0}) begin
        if (i < 3) begin
          n_fail++;
          $display("FAIL zero_b2b[%0d]: so=%b busy=%b cnt=%0d want 1 0 0",
                   i, so_a, busy_a, cnt_a);
        end
      end
      if (i == 3) begin
        n_chk++;
        if (so_a !== 1'b0 || so_b !== 1'b0) begin
          n_fail++;
          $display("FAIL zero_end: so_a=%b so_b=%b want 0", so_a, so_b);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic         exp_so  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic [W-1:0] exp_cnt [8] = '{4, 3, 3, 3, 3, 2, 1, 0};
    do_reset();
    delay = 16'd4; sync_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ena = !(i >= 2 && i <= 4);
      step();
      sync_in = 1'b0;
      n_chk++;
      if ({so_a, cnt_a} !== {exp_so[i], exp_cnt[i]}) begin
        n_fail++;
        $display("FAIL stall[%0d]: so=%b cnt=%0d want %b %0d",
                 i, so_a, cnt_a, exp_so[i], exp_cnt[i]);
      end
    end
    ena = 1'b1;
    delay = 16'd0; sync_in = 1'b1;
    step();
    ena = 1'b0;
    step();
    n_chk++;
    if (so_a !== 1'b0 || so_b !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_ena0: so_a=%b so_b=%b want 0", so_a, so_b);
    end
    step();
    ena = 1'b1; sync_in = 1'b0;
    step();
    n_chk++;
    if (so_a !== 1'b0 || ovr_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL lost_sync: so=%b ovr=%b busy=%b want 0 0 0",
               so_a, ovr_a, busy_a);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    delay = 16'd8; sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    step(); step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    n_chk++;
    if ({ovr_a, cnt_a, ovr_b, cnt_b} !== {1'b1, 16'd5, 1'b0, 16'd8}) begin
      n_fail++;
      $display("FAIL ovr_edge: ovr_a=%b cnt_a=%0d ovr_b=%b cnt_b=%0d want 1 5 0 8",
               ovr_a, cnt_a, ovr_b, cnt_b);
    end
    for (int c = 15; c <= 24; c++) begin
      step();
      n_chk++;
      if (so_a !== (c == 19) || so_b !== (c == 22)) begin
        n_fail++;
        $display("FAIL ovr_pulse[c%0d]: so_a=%b so_b=%b want %b %b",
                 c, so_a, so_b, c == 19, c == 22);
      end
    end
    n_chk++;
    if (ovr_a !== 1'b1 || ovr_b !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_sticky: ovr_a=%b ovr_b=%b want 1 0", ovr_a, ovr_b);
    end
    do_reset();
    n_chk++;
    if (ovr_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: ovr_a=%b want 0", ovr_a);
    end
  endtask

  task automatic test_expiry_retrig();
    do_reset();
    delay = 16'd2; sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    n_chk++;
    if ({so_a, busy_a, ovr_a, so_b, busy_b, cnt_b} !==
        {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2}) begin
      n_fail++;
      $display("FAIL exp_edge: a so/busy/ovr=%b%b%b b so/busy/cnt=%b%b%0d want 101 112",
               so_a, busy_a, ovr_a, so_b, busy_b, cnt_b);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_chk++;
      if (so_a !== 1'b0 || so_b !== (i == 2)) begin
        n_fail++;
        $display("FAIL exp_second[%0d]: so_a=%b so_b=%b want 0 %b",
                 i, so_a, so_b, i == 2);
      end
    end
  endtask

  task automatic test_expiry_zero();
    do_reset();
    delay = 16'd2; sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    step();
    delay = 16'd0; sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    n_chk++;
    if ({so_b, busy_b, so_a} !== 3'b101) begin
      n_fail++;
      $display("FAIL expz_edge: so_b=%b busy_b=%b so_a=%b want 1 0 1",
               so_b, busy_b, so_a);
    end
    step();
    n_chk++;
    if ({so_b, busy_b, so_a} !== 3'b100) begin
      n_fail++;
      $display("FAIL expz_next: so_b=%b busy_b=%b so_a=%b want 1 0 0",
               so_b, busy_b, so_a);
    end
    step();
    n_chk++;
    if (so_b !== 1'b0) begin
      n_fail++;
      $display("FAIL expz_end: so_b=%b want 0", so_b);
    end
    do_reset();
    delay = 16'd6; sync_in = 1'b1;
    step(); step();
    delay = 16'd0;
    step();
    sync_in = 1'b0;
    n_chk++;
    if ({so_b, busy_b, cnt_b} !== {1'b1, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL retrig_zero: so=%b busy=%b cnt=%0d want 1 0 0",
               so_b, busy_b, cnt_b);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    delay = 16'd10; sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if ({so_a, busy_a, cnt_a, so_b, busy_b, cnt_b} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: a=%b%b%0d b=%b%b%0d want all 0",
               so_a, busy_a, cnt_a, so_b, busy_b, cnt_b);
    end
    for (int i = 0; i < 14; i++) begin
      step();
      n_chk++;
      if (so_a !== 1'b0 || so_b !== 1'b0 || busy_a !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_quiet[%0d]: so_a=%b so_b=%b busy_a=%b want 0",
                 i, so_a, so_b, busy_a);
      end
    end
  endtask

  task automatic test_max_delay();
    do_reset();
    delay = 16'hFFFF; sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    step();
    n_chk++;
    if (cnt_a !== 16'hFFFE || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL max_delay: cnt=%0h busy=%b want fffe 1", cnt_a, busy_a);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; sync_in = 1'b0; delay = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_overrun();
    test_expiry_retrig();
    test_expiry_zero();
    test_reset_mid();
    test_max_delay();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_delay_ctrl.md
Name: sync_delay_ctrl

Overview:
- Programmable sync-pulse delay and control stage that sits directly upstream of the biplex FFT up/down counter (counter1).
- Takes the system sync pulse and emits a single-cycle sync_out a programmed number of cycles later.
- sync_out drives the counter's rst input, which aligns the counter, and therefore the FFT frame, to the delayed sync.
- Also reports the remaining delay, a busy flag and a sticky overrun flag for missed syncs.

Parameters:
- DELAY_W, 16, width of the delay value and of the internal down-counter.
- RETRIG, 0, 1 = a sync_in arriving while counting reloads the delay; 0 = it is ignored and flagged as overrun.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  clock enable; when low, all state holds and sync_out is 0.
- sync_in  input  1  sync pulse; sampled only on edges where ena=1.
- delay  input  DELAY_W  delay value, captured only when a sync_in is accepted.
- sync_out  output  1  registered single-cycle pulse, feeds counter1 rst.
- busy  output  1  1 while in state COUNT.
- count_left  output  DELAY_W  remaining down-counter value; 0 in IDLE.
- overrun  output  1  sticky flag: a sync_in was dropped (RETRIG=0 only).

Behaviour:
- Reset (rst=1 at an edge) has priority over everything, ena included.
  - State goes to IDLE.
  - sync_out=0, busy=0, count_left=0, overrun=0.
  - Any pending delay is dropped; no sync_out is issued for it.
- States: IDLE, COUNT. busy is 1 exactly when the state is COUNT.
- Edges with ena=0: state, count_left and overrun hold; sync_out is driven to 0. A sync_in on such an edge is lost and is not flagged.
- IDLE, edge with ena=1 and sync_in=1 (the accept edge):
  - delay=0: sync_out<=1; stay in IDLE; count_left stays 0.
  - delay>0: count_left<=delay; go to COUNT; sync_out<=0.
- COUNT, edge with ena=1:
  - count_left=1: sync_out<=1; count_left<=0; go to IDLE.
  - count_left>1: count_left<=count_left-1; sync_out<=0.
- Latency: sync_out is high during the ena-cycle that follows the delay-th enabled edge after the accept edge. This gives delay+1 cycles from sync_in to sync_out when ena is held high; delay=0 gives 1 cycle.
- sync_out is never high for two consecutive cycles from one accepted sync. Back-to-back accepts in IDLE with delay=0 produce back-to-back pulses.
- sync_in while in COUNT, RETRIG=0: ignored; overrun<=1 (sticky until rst). The original countdown continues.
- sync_in while in COUNT, RETRIG=1: count_left<=delay (new value), or go to IDLE and pulse if delay=0. The original pending pulse is cancelled; overrun stays 0.
- Simultaneous expiry (count_left=1) and sync_in:
  - RETRIG=0: sync_out fires, state goes to IDLE, overrun is set, and the new sync is not accepted.
  - RETRIG=1: sync_out fires and the new delay is loaded. State becomes COUNT if delay>0; if delay=0 the state stays IDLE and sync_out is also high the next cycle.
- delay may change at any time; only the value present on the accept or reload edge matters.
- Width: the down-counter is DELAY_W bits. The maximum delay is 2^DELAY_W-1, and no wrap is possible.

Test Plan:
- Basic delay: rst for 2 cycles, ena=1, delay=5, sync_in 1-cycle pulse at cycle 10 -> sync_out high at cycle 16 only; busy high cycles 11-15; count_left 5,4,3,2,1 then 0.
- Zero delay and back-to-back: delay=0, sync_in high for cycles 20-22 -> sync_out high for cycles 21-23; busy stays 0.
- Enable stall: delay=4, sync at cycle 10, ena=0 for cycles 12-14 -> count_left frozen at 3 during the stall; sync_out at cycle 18; sync_out is never high while ena=0.
- Overrun, RETRIG=0: delay=8, syncs at cycles 10 and 13 -> single sync_out at cycle 19; overrun=1 from cycle 14 until the next rst.
- Retrigger, RETRIG=1: delay=8, syncs at cycles 10 and 13 -> no pulse at cycle 19; sync_out at cycle 22; overrun=0. Also a sync at the expiry edge with delay=2 -> pulse at expiry plus a second pulse 3 cycles later.
- Reset mid-count: delay=10, sync at cycle 5, rst at cycle 9 -> all outputs 0 from cycle 10; no sync_out ever. With counter1 attached, count_out returns to 0 one cycle after each sync_out.
